sme_share_mover: RTL and testbench

Sequencing engine that owns the read port and write port of one SME 16-entry share register file. It moves a run of consecutive shares in one of two directions:
- Load: from a streaming input into the regfile.
- Store: from the regfile out to a streaming output.

It sits between the SME load/store datapath and the share regfile, and issues every regfile address and write strobe for bulk share transfers.

---
 rtl/sme_share_mover.sv | 116 +++++++++++
 tb/tb_sme_share_mover.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_share_mover.sv
// Bulk share mover for one 16-entry SME share register file.
// Loads stream in_data into the regfile; stores stream regfile entries out.
module sme_share_mover #(
   parameter int XLEN = 32
) (
   input  logic              g_clk,
   input  logic              g_reset,
   output logic              g_clk_req,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_store,
   input  logic [3:0]        cmd_base,
   input  logic [3:0]        cmd_len,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_data,
   output logic [3:0]        out_idx,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_data,
   output logic [3:0]        rs1_addr,
   input  logic [XLEN-1:0]   rs1_rdata,
   output logic              rd_wen,
   output logic [3:0]        rd_addr,
   output logic [XLEN-1:0]   rd_wdata
);

   localparam int XL = XLEN - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_STORE = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t        r_state;
   logic [3:0]    r_ptr;
   logic [4:0]    r_rem;
   logic          r_done;
   logic          r_rd_wen;
   logic [3:0]    r_rd_addr;
   logic [XL:0]   r_rd_wdata;

   logic          w_last;

   assign w_last = (r_rem == 5'd1);

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         r_state    <= S_IDLE;
         r_ptr      <= 4'd0;
         r_rem      <= 5'd0;
         r_done     <= 1'b0;
         r_rd_wen   <= 1'b0;
         r_rd_addr  <= 4'd0;
         r_rd_wdata <= '0;
      end else begin
         r_done   <= 1'b0;
         r_rd_wen <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_ptr   <= cmd_base;
                  r_rem   <= {1'b0, cmd_len} + 5'd1;
                  r_state <= cmd_store ? S_STORE : S_LOAD;
               end
            end
            S_STORE: begin
               if (out_ready) begin
                  r_ptr <= r_ptr + 4'd1;
                  r_rem <= r_rem - 5'd1;
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               // Write lands one cycle after its accept; DRAIN covers the last one.
               if (in_valid) begin
                  r_rd_wen   <= 1'b1;
                  r_rd_addr  <= r_ptr;
                  r_rd_wdata <= in_data;
                  r_ptr      <= r_ptr + 4'd1;
                  r_rem      <= r_rem - 5'd1;
                  if (w_last) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               r_state <= S_IDLE;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign out_valid = (r_state == S_STORE);
   assign in_ready  = (r_state == S_LOAD);
   assign g_clk_req = (r_state != S_IDLE) || cmd_valid;
   assign done      = r_done;
   assign rs1_addr  = r_ptr;
   assign out_idx   = r_ptr;
   assign out_data  = rs1_rdata;
   assign rd_wen    = r_rd_wen;
   assign rd_addr   = r_rd_addr;
   assign rd_wdata  = r_rd_wdata;

endmodule

// File: tb/tb_sme_share_mover.sv
// Directed bench for sme_share_mover with an attached regfile and write/store scoreboards.
module tb_sme_share_mover;

   logic          g_clk;
   logic          g_reset;
   logic          g_clk_req;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_store;
   logic [3:0]    cmd_base;
   logic [3:0]    cmd_len;
   logic          done;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic [3:0]    out_idx;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_data;
   logic [3:0]    rs1_addr;
   logic [31:0]   rs1_rdata;
   logic          rd_wen;
   logic [3:0]    rd_addr;
   logic [31:0]   rd_wdata;

   sme_share_mover #(.XLEN(32)) dut (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .g_clk_req (g_clk_req),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_store (cmd_store),
      .cmd_base  (cmd_base),
      .cmd_len   (cmd_len),
      .done      (done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rs1_addr  (rs1_addr),
      .rs1_rdata (rs1_rdata),
      .rd_wen    (rd_wen),
      .rd_addr   (rd_addr),
      .rd_wdata  (rd_wdata)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   // Regfile driven by the DUT write port; exp_rf is the bench's own view of intended contents.
   logic [31:0] rf [16];
   logic [31:0] exp_rf [16];
   assign rs1_rdata = rf[rs1_addr];
   always @(posedge g_clk) if (rd_wen) rf[rd_addr] <= rd_wdata;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
      int          stamp;
   } wr_t;

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] data;
   } st_t;

   wr_t wq[$];
   st_t sq[$];
   wr_t w_mon;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;

   always @(posedge g_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Write-port monitor: every regfile write must match the oldest accepted load beat.
   always @(negedge g_clk) begin
      if (rd_wen) begin
         if (wq.size() == 0) begin
            chk("wr_unexpected", 64'd1, 64'd0);
         end else begin
            w_mon = wq.pop_front();
            chk("wr_addr", 64'(rd_addr), 64'(w_mon.addr));
            chk("wr_data", 64'(rd_wdata), 64'(w_mon.data));
            chk("wr_cycle", 64'(cyc), 64'(w_mon.stamp));
         end
      end
      if (done) done_cnt++;
   end

   task automatic issue_cmd(input logic st, input logic [3:0] base, input logic [3:0] len);
      for (int k = 0; k < 20 && !cmd_ready; k++) begin
         @(posedge g_clk); #1;
      end
      chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_store = st;
      cmd_base  = base;
      cmd_len   = len;
      #1;
      chk("clk_req_cmd", 64'(g_clk_req), 64'd1);
      @(posedge g_clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_load(input logic [3:0] base, input logic [3:0] len,
                          input logic [31:0] d0, input int stop_after);
      int          n;
      int          dc;
      logic [3:0]  a;
      wr_t         w;
      n = int'(len) + 1;
      issue_cmd(1'b0, base, len);
      dc = done_cnt;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = d0 + 32'(i);
         #3;
         chk("ld_in_ready", 64'(in_ready), 64'd1);
         chk("ld_clk_req", 64'(g_clk_req), 64'd1);
         @(posedge g_clk); #1;
         a = base + 4'(i);
         w.addr  = a;
         w.data  = d0 + 32'(i);
         w.stamp = cyc;
         wq.push_back(w);
         exp_rf[a] = d0 + 32'(i);
         if (i + 1 == stop_after) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      chk("ld_drain_in_ready", 64'(in_ready), 64'd0);
      chk("ld_drain_done", 64'(done), 64'd0);
      chk("ld_drain_wen", 64'(rd_wen), 64'd1);
      @(posedge g_clk); #1;
      chk("ld_done", 64'(done), 64'd1);
      chk("ld_done_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge g_clk); #1;
      chk("ld_done_low", 64'(done), 64'd0);
      chk("ld_done_once", 64'(done_cnt - dc), 64'd1);
   endtask

   task automatic do_store(input logic [3:0] base, input logic [3:0] len, input logic [31:0] mask);
      int          n;
      int          dc;
      int          c;
      logic [3:0]  a;
      st_t         s;
      n = int'(len) + 1;
      for (int i = 0; i < n; i++) begin
         a = base + 4'(i);
         s.idx  = a;
         s.data = exp_rf[a];
         sq.push_back(s);
      end
      issue_cmd(1'b1, base, len);
      dc = done_cnt;
      c  = 0;
      while (sq.size() > 0 && c < 64) begin
         out_ready = (c < 32) ? mask[c] : 1'b1;
         #3;
         chk("st_valid", 64'(out_valid), 64'd1);
         chk("st_idx", 64'(out_idx), 64'(sq[0].idx));
         chk("st_data", 64'(out_data), 64'(sq[0].data));
         @(posedge g_clk); #1;
         if (out_ready) void'(sq.pop_front());
         c++;
      end
      chk("st_budget", 64'(sq.size()), 64'd0);
      sq.delete();
      out_ready = 1'b0;
      chk("st_done", 64'(done), 64'd1);
      chk("st_valid_off", 64'(out_valid), 64'd0);
      @(posedge g_clk); #1;
      chk("st_done_low", 64'(done), 64'd0);
      chk("st_done_once", 64'(done_cnt - dc), 64'd1);
   endtask

   initial begin
      int dc;
      for (int i = 0; i < 16; i++) begin
         rf[i]     = 32'd0;
         exp_rf[i] = 32'd0;
      end
      g_reset   = 1'b1;
      cmd_valid = 1'b0;
      cmd_store = 1'b0;
      cmd_base  = 4'd0;
      cmd_len   = 4'd0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      repeat (3) @(posedge g_clk);
      #1;
      g_reset = 1'b0;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_rd_wen", 64'(rd_wen), 64'd0);
      chk("rst_clk_req", 64'(g_clk_req), 64'd0);

      do_load(4'd0, 4'd3, 32'hA0, -1);
      do_store(4'd0, 4'd3, 32'hFFFF_FFFF);

      do_load(4'd14, 4'd3, 32'd1, -1);
      do_store(4'd14, 4'd3, 32'hFFFF_FFFF);

      // Stall pattern 1-0-0-1-1 then always ready.
      do_store(4'd0, 4'd3, 32'hFFFF_FFF9);

      do_load(4'd5, 4'd15, 32'h1000, -1);
      do_store(4'd5, 4'd15, 32'hFFFF_FFFF);

      // Abort a load after two of four beats.
      dc = done_cnt;
      do_load(4'd4, 4'd3, 32'hB0, 2);
      in_valid = 1'b1;
      in_data  = 32'hB2;
      g_reset  = 1'b1;
      @(posedge g_clk); #1;
      g_reset  = 1'b0;
      in_valid = 1'b0;
      chk("abort_rd_wen", 64'(rd_wen), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("abort_done", 64'(done), 64'd0);
      repeat (3) @(posedge g_clk);
      #1;
      chk("abort_no_done", 64'(done_cnt - dc), 64'd0);
      do_store(4'd4, 4'd1, 32'hFFFF_FFFF);

      chk("wq_empty", 64'(wq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
